mas_mod_accumulator: RTL and testbench

Downstream consumer of the 2-input modular add/sub stage. Takes that stage's reduced result (`Dout`) and its comparator code (`Tcmp`) one sample per handshake and accumulates a frame of `FRAME_LEN` samples modulo `Q`. At frame end it presents the modular sum, a count of comparator corrections and an error flag through a valid/ready output handshake.

---
 rtl/mas_mod_accumulator_pkg.sv | 20 ++
 rtl/mas_mod_accumulator_mod_add_step.sv | 38 +++
 rtl/mas_mod_accumulator.sv | 95 +++++++++
 tb/tb_mas_mod_accumulator.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mas_mod_accumulator_pkg.sv
// Shared definitions for the modular accumulator: FSM states, modulus limits
// and datapath widths.
package mas_mod_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int Q_MIN  = 2;
  localparam int Q_MAX  = 15;
  localparam int DATA_W = 4;
  localparam int Q_W    = 5;

  function automatic logic q_legal(input logic signed [Q_W-1:0] q);
    return (int'(q) >= Q_MIN) && (int'(q) <= Q_MAX);
  endfunction

endpackage

// File: rtl/mas_mod_accumulator_mod_add_step.sv
// One modular accumulation step: acc + Din reduced by a single conditional subtract.
// Purely combinational; out-of-range samples and illegal moduli contribute nothing.
module mod_add_step
  import mas_mod_accumulator_pkg::*;
(
  input  logic [DATA_W-1:0]       acc,
  input  logic [DATA_W-1:0]       din,
  input  logic signed [Q_W-1:0]   q,
  output logic [DATA_W-1:0]       acc_next,
  output logic                    bad_din,
  output logic                    bad_q
);

  logic [Q_W-1:0] qu;
  logic [Q_W-1:0] d;
  logic [Q_W-1:0] sum;
  logic [Q_W-1:0] red;

  assign qu = Q_W'(q);

  always_comb begin
    bad_q    = !q_legal(q);
    bad_din  = 1'b0;
    d        = '0;
    sum      = '0;
    red      = '0;
    acc_next = '0;
    if (!bad_q) begin
      bad_din = {1'b0, din} >= qu;
      d       = bad_din ? '0 : {1'b0, din};
      // acc < q and d < q, so sum < 2q and one subtract fully reduces it
      sum      = {1'b0, acc} + d;
      red      = (sum >= qu) ? (sum - qu) : sum;
      acc_next = red[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/mas_mod_accumulator.sv
// Accumulates FRAME_LEN samples modulo Q; result appears the cycle after the last accept.
// in_ready drops while a result waits in DONE, so the upstream holds its sample.
module mas_mod_accumulator
  import mas_mod_accumulator_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       Din,
  input  logic [1:0]              Tcmp,
  input  logic signed [Q_W-1:0]   Q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       acc_out,
  output logic [CNT_W-1:0]        corr_cnt,
  output logic                    frame_err
);

  state_t                 state, state_nxt;
  logic signed [Q_W-1:0]  q_r;
  logic signed [Q_W-1:0]  q_cur;
  logic [7:0]             cnt_r;
  logic [DATA_W-1:0]      acc_r;
  logic [CNT_W-1:0]       corr_r;
  logic                   err_r;
  logic                   out_valid_r;
  logic [DATA_W-1:0]      acc_next;
  logic                   bad_din;
  logic                   bad_q;
  logic                   accept;

  assign accept = in_valid && in_ready;
  // The first sample of a frame is processed against the live Q it latches
  assign q_cur  = (state == IDLE) ? Q : q_r;

  mod_add_step u_step (
    .acc      (acc_r),
    .din      (Din),
    .q        (q_cur),
    .acc_next (acc_next),
    .bad_din  (bad_din),
    .bad_q    (bad_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = rst_n && (state != DONE);
    case (state)
      IDLE:    if (accept) state_nxt = (FRAME_LEN == 1) ? DONE : ACCUM;
      ACCUM:   if (accept && (cnt_r + 8'd1 == 8'(FRAME_LEN))) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r         <= '0;
      cnt_r       <= '0;
      acc_r       <= '0;
      corr_r      <= '0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (state_nxt == DONE);
      if (accept) begin
        if (state == IDLE) q_r <= Q;
        cnt_r  <= (state == IDLE) ? 8'd1 : cnt_r + 8'd1;
        acc_r  <= acc_next;
        corr_r <= corr_r + CNT_W'(Tcmp != 2'b00);
        err_r  <= err_r | bad_din | bad_q;
      end else if (state == DONE && out_ready) begin
        cnt_r  <= '0;
        acc_r  <= '0;
        corr_r <= '0;
        err_r  <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign acc_out   = acc_r;
  assign corr_cnt  = corr_r;
  assign frame_err = err_r;

endmodule

// File: tb/tb_mas_mod_accumulator.sv
// Directed-vector bench for mas_mod_accumulator with FRAME_LEN=4.
module tb_mas_mod_accumulator;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        Din;
  logic [1:0]        Tcmp;
  logic signed [4:0] Q;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        acc_out;
  logic [2:0]        corr_cnt;
  logic              frame_err;

  int checks   = 0;
  int failures = 0;

  mas_mod_accumulator #(.FRAME_LEN(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Din       (Din),
    .Tcmp      (Tcmp),
    .Q         (Q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .corr_cnt  (corr_cnt),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Streams four samples back-to-back; first sample uses q0, the rest q1.
  task automatic send_frame(input logic signed [4:0] q0, input logic signed [4:0] q1,
                            input logic [15:0] ds, input logic [7:0] ts);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      Din      = ds[4*i +: 4];
      Tcmp     = ts[2*i +: 2];
      Q        = (i == 0) ? q0 : q1;
      chk("in_ready_stream", in_ready, 1);
      chk("out_valid_early", out_valid, 0);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("out_valid_rise", out_valid, 1);
    chk("in_ready_done", in_ready, 0);
  endtask

  task automatic check_result(input string tag, input int acc, input int corr, input int err);
    chk({tag, "_acc"}, acc_out, acc);
    chk({tag, "_corr"}, corr_cnt, corr);
    chk({tag, "_err"}, frame_err, err);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; Din = '0; Tcmp = '0; Q = 5'sd7; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    check_result("rst", 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // basic: Din 3,5,6,2 (index 0 first), Tcmp 00,01,00,10
    send_frame(5'sd7, 5'sd7, {4'd2, 4'd6, 4'd5, 4'd3}, {2'b10, 2'b00, 2'b01, 2'b00});
    check_result("basic", 2, 2, 0);
    consume();

    send_frame(5'sd15, 5'sd15, {4'd14, 4'd14, 4'd14, 4'd14}, 8'h00);
    check_result("wrap", 11, 0, 0);
    consume();

    send_frame(5'sd5, 5'sd5, {4'd1, 4'd1, 4'd6, 4'd4}, 8'h00);
    check_result("illegal_din", 1, 0, 1);

    // backpressure on the pending illegal_din result
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; Din = 4'd3;
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      check_result("bp_hold", 1, 0, 1);
    end
    in_valid = 1'b0;
    consume();

    send_frame(5'sd7, 5'sd3, {4'd2, 4'd6, 4'd5, 4'd3}, {2'b10, 2'b00, 2'b01, 2'b00});
    check_result("q_change", 2, 2, 0);
    consume();

    send_frame(5'sd1, 5'sd1, 16'h0000, 8'h55);
    check_result("illegal_q", 0, 4, 1);
    consume();

    // reset after two accepts
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; Din = 4'd5; Tcmp = 2'b01; Q = 5'sd7;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    check_result("midrst", 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_after", in_ready, 1);

    send_frame(5'sd7, 5'sd7, {4'd1, 4'd1, 4'd1, 4'd1}, 8'h00);
    check_result("after_rst", 4, 0, 0);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
